// File: rtl/wf_seq_addr_gen.sv
// Waveform-playback sequencer: steps a BRAM address through a runtime-selected
// waveform length, counts samples and wraps, and flags half/full buffer consumption.
module wf_seq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1000,
    parameter int CNT_W  = 32,
    parameter int CYC_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sw_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode,
    input  logic [CNT_W-1:0]  i_total_count,
    input  logic [ADDR_W:0]   i_wf_len,
    input  logic              i_tick,
    output logic              o_cs,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CNT_W-1:0]  o_count,
    output logic [CYC_W-1:0]  o_cycles,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_int_half,
    output logic              o_int_full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_TWO   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CYC_W-1:0]    cycles_q, cycles_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                cs_q, cs_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                half_q, half_d;
    logic                full_q, full_d;

    logic                cfg_ok;
    logic                at_last;
    logic                at_half;
    logic [ADDR_W:0]     addr_ext;

    always_comb begin
        cfg_ok   = (i_wf_len >= LEN_TWO) && (i_wf_len <= LEN_DEPTH)
                   && (i_mode || (i_total_count != '0));
        addr_ext = {1'b0, addr_q};
        at_last  = (addr_ext == (len_q - LEN_ONE));
        at_half  = (addr_ext == ((len_q >> 1) - LEN_ONE));

        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        cycles_d = cycles_q;
        mode_d   = mode_q;
        total_d  = total_q;
        len_d    = len_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        half_d   = 1'b0;
        full_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (cfg_ok) begin
                        state_d  = ST_RUN;
                        mode_d   = i_mode;
                        total_d  = i_total_count;
                        len_d    = i_wf_len;
                        addr_d   = '0;
                        count_d  = '0;
                        cycles_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Stop takes priority: a coincident tick is dropped entirely.
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else if (i_tick) begin
                    addr_d  = at_last ? '0 : addr_q + ADDR_ONE;
                    count_d = count_q + CNT_ONE;
                    half_d  = at_half;
                    full_d  = at_last;
                    if (at_last && (cycles_q != '1)) begin
                        cycles_d = cycles_q + CYC_ONE;
                    end
                    if (!mode_q && (count_q == (total_q - CNT_ONE))) begin
                        state_d = ST_DONE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_d = (state_d == ST_RUN);

        // Soft reset behaves like the hard reset, applied at the clock edge.
        if (!i_sw_rst) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            count_d  = '0;
            cycles_d = '0;
            mode_d   = 1'b0;
            total_d  = '0;
            len_d    = '0;
            cs_d     = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            half_d   = 1'b0;
            full_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            cycles_q <= '0;
            mode_q   <= 1'b0;
            total_q  <= '0;
            len_q    <= '0;
            cs_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            half_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
            mode_q   <= mode_d;
            total_q  <= total_d;
            len_q    <= len_d;
            cs_q     <= cs_d;
            done_q   <= done_d;
            err_q    <= err_d;
            half_q   <= half_d;
            full_q   <= full_d;
        end
    end

    assign o_cs       = cs_q;
    assign o_busy     = cs_q;
    assign o_addr     = addr_q;
    assign o_count    = count_q;
    assign o_cycles   = cycles_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_int_half = half_q;
    assign o_int_full = full_q;

endmodule

// File: doc/wf_seq_addr_gen.md
Name: wf_seq_addr_gen

Overview:
Parametrised waveform-playback address/sample sequencer for the MPS PL. Replaces the fixed 1000-entry waveform counter. Drives BRAM chip-select and address for a runtime-selectable waveform length, and counts consumed samples in finite or continuous mode. Raises half-buffer and full-buffer pulses so the PS can refill the buffer half that is not being played.

Parameters:
ADDR_W, 10, BRAM address width.
DEPTH, 1000, maximum waveform length in samples; must satisfy DEPTH <= 2^ADDR_W.
CNT_W, 32, width of the sample counter and of the total-count input.
CYC_W, 16, width of the completed-cycle counter.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_sw_rst  in  1  synchronous active-low soft reset from PS; same effect as i_rst, one cycle later
i_start  in  1  start pulse; sampled in IDLE only
i_stop  in  1  abort; sampled in RUN only
i_mode  in  1  0 = finite (stop after i_total_count samples), 1 = continuous
i_total_count  in  CNT_W  samples to play in finite mode
i_wf_len  in  ADDR_W+1  waveform length in samples, valid range 2..DEPTH
i_tick  in  1  sample-advance strobe (one cycle per sample)
o_cs  out  1  BRAM chip-select
o_addr  out  ADDR_W  BRAM address
o_count  out  CNT_W  samples consumed since the last start
o_cycles  out  CYC_W  completed address wraps since the last start
o_busy  out  1  high in RUN
o_done  out  1  1-cycle pulse on finite-mode completion
o_err  out  1  1-cycle pulse when a start is rejected
o_int_half  out  1  1-cycle pulse when the first half of the buffer is consumed
o_int_full  out  1  1-cycle pulse when the second half of the buffer is consumed

Behaviour:
- Reset (i_rst low, or i_sw_rst low at a clock edge): state = IDLE. All outputs = 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE -> RUN on i_start when the configuration is valid:
  - i_wf_len is in 2..DEPTH, and
  - i_mode = 1, or i_total_count != 0.
- On a valid start: latch mode, total and len; clear o_addr, o_count and o_cycles to 0. Later config changes during RUN are ignored.
- Invalid start: stay in IDLE, pulse o_err the next cycle, leave counters unchanged.
- o_cs and o_busy are 1 exactly while state = RUN. They rise on the cycle after i_start is sampled.
- RUN, on i_tick (all updates take effect the next cycle):
  - o_addr = (o_addr == len-1) ? 0 : o_addr + 1.
  - o_count increments; it wraps modulo 2^CNT_W in continuous mode.
  - o_cycles increments, saturating at all-ones, when o_addr == len-1.
- i_tick in IDLE or DONE is ignored.
- Interrupts, evaluated on a RUN tick using the pre-tick address:
  - addr == (len>>1)-1 -> o_int_half pulses the next cycle.
  - addr == len-1 -> o_int_full pulses the next cycle.
  - For len = 2: half fires at addr 0, full fires at addr 1.
- Finite completion: a tick with o_count == total-1 moves the state to DONE.
  - o_count = total; o_addr = 0 on entry to DONE.
  - Interrupts triggered by that final tick still fire.
- DONE lasts one cycle: o_done = 1, o_cs = 0, then the state returns to IDLE.
- o_count and o_cycles hold their values in IDLE until the next valid start.
- i_stop in RUN: go to IDLE next cycle. o_addr = 0, o_count and o_cycles hold, no o_done.
  - i_stop and i_tick in the same cycle: stop wins, the tick is discarded, no interrupt fires.
- i_start during RUN or DONE is ignored. A restart requires IDLE.
- Continuous mode leaves RUN only via i_stop or reset.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. No pulses are generated.

Test Plan:
- Finite, len=8, total=20, tick every cycle:
  - o_addr sequence 0..7,0..7,0..3.
  - o_int_half after pre-tick addr 3 (x3); o_int_full after pre-tick addr 7 (x2).
  - o_cycles=2, o_count=20, o_done pulses once; o_cs low from the DONE cycle onward.
- Continuous, len=1000, 2500 ticks, then i_stop:
  - o_cycles=2, o_addr=500 before the stop; o_addr=0 after; no o_done.
  - o_int_half x3, o_int_full x2.
- Invalid starts, each -> o_err pulse, state stays IDLE, o_cs=0:
  - len=1; len=DEPTH+1; mode=0 with total=0.
- Stop and tick in the same cycle at addr 5:
  - next cycle IDLE, o_addr=0, o_count unchanged, no interrupt pulse.
- Async i_rst mid-RUN (addr 300): all outputs 0 immediately. Then i_sw_rst low for one cycle during RUN: IDLE next edge. A fresh start afterwards restarts at addr 0.
- Config change during RUN (i_wf_len 8 -> 4 after start): the wrap stays at 7. A start request while in RUN is ignored.
